// File: rtl/rd_arbiter.sv
// Round-robin arbiter that shares one read-cycle engine between NREQ requesters.
// Runs each grant through a fixed read / delay / strobe / wait sequence on go.
module rd_arbiter #(
  parameter int NREQ    = 4,
  parameter int RD_CYC  = 4,
  parameter int DLY_CYC = 2,
  parameter int TO_CYC  = 8,
  parameter int CW      = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_ds,
  output logic [NREQ-1:0] o_gnt,
  output logic            o_go,
  output logic [NREQ-1:0] o_done,
  output logic            o_err,
  output logic            o_busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DLY,
    S_STRB,
    S_WAIT
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [IW-1:0]   r_last;

  logic            w_pick_vld;
  logic [IW-1:0]   w_pick_idx;
  logic [NREQ-1:0] w_pick_oh;
  int              w_dist;
  int              w_best;

  // Distance of each requester from the slot after the last grant; the nearest one wins.
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick_idx = '0;
    w_dist     = 0;
    w_best     = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      if (i_req[i]) begin
        w_dist = (i + NREQ - 1 - int'(r_last)) % NREQ;
        if (w_dist < w_best) begin
          w_best     = w_dist;
          w_pick_vld = 1'b1;
          w_pick_idx = IW'(i);
        end
      end
    end
  end

  always_comb begin
    w_pick_oh = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_pick_oh[i] = (w_pick_idx == IW'(i));
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_last  <= IW'(NREQ - 1);
      o_gnt   <= '0;
      o_go    <= 1'b0;
      o_done  <= '0;
      o_err   <= 1'b0;
      o_busy  <= 1'b0;
    end else begin
      o_done <= '0;
      o_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pick_vld) begin
            o_gnt   <= w_pick_oh;
            r_last  <= w_pick_idx;
            r_cnt   <= CW'(RD_CYC - 1);
            o_go    <= 1'b1;
            o_busy  <= 1'b1;
            r_state <= S_READ;
          end
        end
        S_READ: begin
          if (r_cnt == '0) begin
            r_cnt   <= CW'(DLY_CYC - 1);
            o_go    <= 1'b0;
            r_state <= S_DLY;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DLY: begin
          if (r_cnt == '0) begin
            o_go    <= 1'b1;
            r_state <= S_STRB;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_STRB: begin
          r_cnt   <= CW'(TO_CYC - 1);
          o_go    <= 1'b0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // ds wins over the terminal count, so a strobe in the last cycle still succeeds.
          if (i_ds) begin
            o_done  <= o_gnt;
            o_gnt   <= '0;
            o_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_cnt == '0) begin
            o_err   <= 1'b1;
            o_gnt   <= '0;
            o_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          o_gnt   <= '0;
          o_go    <= 1'b0;
          o_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
